deserializer: RTL and testbench
===============================

# deserializer

Collects a serial stream of 16-bit chunks into one 256-bit parallel frame of eight complex words (16-bit upper/lower halves) and presents it to the FFT core with a one-cycle completion pulse. Sits directly upstream of the FFT core and mirrors the chunk ordering of the output serializer, so a serializer-to-deserializer loopback reproduces the frame bit-for-bit. The assembled frame is held stable while the next frame accumulates.

## Interface
- INPUT_SIZE, 16: width of each serial input chunk.
- OUTPUT_SIZE, 256: width of the assembled parallel frame.
- WORD_SIZE, 32: width of one complex word; must be a multiple of INPUT_SIZE, and OUTPUT_SIZE a multiple of WORD_SIZE.
- clk  input  1  single clock; all state changes on its rising edge.
- reset_n  input  1  reset, asynchronous and active-low.
- input_valid  input  1  input_data holds a chunk to accept this cycle.
- input_data  input  INPUT_SIZE  serial chunk.
- flush  input  1  synchronous abort of the partial frame.
- output_data  output  OUTPUT_SIZE  last completed frame, registered.
- deserialization_done  output  1  one-cycle pulse: output_data just updated.
- busy  output  1  high while a partial frame is held (chunk count nonzero).

## Operation
- NUM_CHUNKS = OUTPUT_SIZE/INPUT_SIZE (16). CPW = WORD_SIZE/INPUT_SIZE (2).
- Chunk counter n runs 0..NUM_CHUNKS-1. Word w = n/CPW. Slot j = n%CPW.
- Chunk n is written to the assembly buffer at bits [w*WORD_SIZE + WORD_SIZE-1 - j*INPUT_SIZE -: INPUT_SIZE]. This puts the upper half of each word first, then word 0 through word 7.
- With the defaults the chunk sequence lands at [31:16], [15:0], [63:48], [47:32], …, [255:240], [239:224].
- States:
  - IDLE: n=0. An accepted chunk moves to COLLECTING with n=1.
  - COLLECTING: each accepted chunk increments n.
  - Accepting chunk NUM_CHUNKS-1 returns to IDLE with n=0.
- On accepting the last chunk:
  - output_data loads the assembly buffer merged with that chunk.
  - deserialization_done is asserted on the next cycle.
  - The assembly buffer is not cleared; stale bits are overwritten by the next frame.
- Gaps in input_valid are allowed anywhere. There is no timeout.
- flush=1: n returns to 0 and the state goes to IDLE. output_data is unchanged and no done pulse is produced.
- flush and input_valid in the same cycle: flush wins and the chunk is discarded.
- No backpressure; every valid chunk is accepted.

## Timing
- Reset values:
  - Outputs: output_data=0, deserialization_done=0, busy=0.
  - Internal: assembly buffer=0, n=0, state IDLE.
- Reset asserted mid-frame discards the partial frame immediately. The first chunk after release is treated as chunk 0.
- Latency: the last chunk is sampled at edge k; output_data and deserialization_done are visible after edge k. The done pulse lasts exactly one cycle.
- Back-to-back frames have zero bubble. A chunk valid in the cycle where done is high is chunk 0 of the next frame.
- busy goes high the cycle after the first chunk is accepted. It goes low the cycle after the last chunk or a flush.
- output_data changes only together with a done pulse.

## Structure
- Shared package fft_pkg holds:
  - DATA_WIDTH=16, COMPLEX_WIDTH=32, NUM_POINTS=8, FRAME_WIDTH=256.
  - The chunk-order rule (upper half first, word 0 first), shared with the serializer.
- Single module with no sub-module. Counter, slot decode and buffers are small enough to stay flat.
- Counter width is $clog2(NUM_CHUNKS).

## Test plan
- Contiguous frame: chunks 0x0001..0x0010 on consecutive cycles -> one done pulse the cycle after the 16th chunk.
  - Expected output_data: [31:16]=0x0001, [15:0]=0x0002, [255:240]=0x000F, [239:224]=0x0010.
- Gapped input: the same 16 chunks with 1–3 idle cycles between them -> identical output_data, a single done pulse, and busy high throughout.
- Back-to-back frames: frame A = 0xA000+i, then frame B = 0xB000+i with no gap.
  - Two done pulses 16 cycles apart.
  - output_data holds frame A, unchanged, until B completes.
- Flush mid-frame: 5 chunks, then flush together with a valid chunk 0xDEAD -> no done pulse, busy=0, output_data unchanged. Then 16 chunks -> correct frame with no 0xDEAD present.
- Async reset after 9 chunks -> all outputs 0 without waiting for a clock edge. A fresh 16-chunk frame after release completes correctly.
- Loopback: random 256-bit frame -> serializer -> deserializer reproduces the identical frame, with exactly one done per frame.

Source files
------------

// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_pkg (package)
// Description : Shared FFT datapath constants and the serial chunk-order rule
//               used by both the output serializer and the input
//               deserializer. A loopback between them reproduces a frame
//               bit-for-bit only if both sides use chunk_lsb() below.
// Contents    : DATA_WIDTH, COMPLEX_WIDTH, NUM_POINTS, FRAME_WIDTH,
//               frame_t, chunk_lsb()
// Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

    localparam int DATA_WIDTH    = 16;
    localparam int COMPLEX_WIDTH = 32;
    localparam int NUM_POINTS    = 8;
    localparam int FRAME_WIDTH   = 256;

    typedef logic [FRAME_WIDTH-1:0] frame_t;

    // Lowest bit position of serial chunk n inside a frame. Within a word the
    // upper half travels first; words travel in ascending order (word 0 first).
    function automatic int unsigned chunk_lsb(
        input int unsigned n,
        input int unsigned word_size,
        input int unsigned chunk_size
    );
        int unsigned cpw;
        int unsigned w;
        int unsigned j;
        cpw = word_size / chunk_size;
        w   = n / cpw;
        j   = n % cpw;
        return (w * word_size) + word_size - ((j + 1) * chunk_size);
    endfunction

endpackage : fft_pkg
`default_nettype wire

// File: rtl/deserializer.sv
`default_nettype none
// ============================================================================
// Module      : deserializer
// Description : Gathers NUM_CHUNKS serial chunks into one parallel frame for
//               the FFT core. The completed frame is registered and held while
//               the next frame accumulates; a one-cycle done pulse marks each
//               update of output_data.
// Ports       : clk                  - clock, rising edge
//               reset_n              - asynchronous active-low reset
//               input_valid          - input_data carries a chunk this cycle
//               input_data           - serial chunk [INPUT_SIZE]
//               flush                - synchronous abort of the partial frame
//               output_data          - last completed frame [OUTPUT_SIZE]
//               deserialization_done - one-cycle pulse, output_data updated
//               busy                 - a partial frame is held
// Revision    : 1.0 - initial release
// ============================================================================
module deserializer
    import fft_pkg::*;
#(
    parameter int INPUT_SIZE  = DATA_WIDTH,
    parameter int OUTPUT_SIZE = FRAME_WIDTH,
    parameter int WORD_SIZE   = COMPLEX_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   input_valid,
    input  logic [INPUT_SIZE-1:0]  input_data,
    input  logic                   flush,
    output logic [OUTPUT_SIZE-1:0] output_data,
    output logic                   deserialization_done,
    output logic                   busy
);

    localparam int NUM_CHUNKS = OUTPUT_SIZE / INPUT_SIZE;
    localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

    localparam logic [0:0] ST_IDLE       = 1'b0;
    localparam logic [0:0] ST_COLLECTING = 1'b1;

    logic [0:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [OUTPUT_SIZE-1:0] asm_q, asm_d;
    logic [OUTPUT_SIZE-1:0] out_q, out_d;
    logic                   done_q, done_d;

    logic                   accept;
    logic                   last_chunk;
    // Assembly buffer with the current chunk already merged into its slot;
    // this is what output_data loads on the final chunk.
    logic [OUTPUT_SIZE-1:0] asm_merged;

    // flush has priority: a chunk presented alongside it is dropped.
    assign accept     = input_valid & ~flush;
    assign last_chunk = (cnt_q == LAST_CHUNK);

    // One slot per chunk position; slot positions are fixed at elaboration,
    // so the write path is a simple per-slot select on the counter value.
    for (genvar k = 0; k < NUM_CHUNKS; k++) begin : g_chunk
        localparam int unsigned LSB = chunk_lsb(k, WORD_SIZE, INPUT_SIZE);
        assign asm_merged[LSB +: INPUT_SIZE] =
            (accept && (cnt_q == CNT_W'(k))) ? input_data
                                             : asm_q[LSB +: INPUT_SIZE];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        done_d  = 1'b0;
        // The buffer is never cleared: each frame overwrites every slot.
        asm_d   = asm_merged;

        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (input_valid) begin
            if (last_chunk) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                out_d   = asm_merged;
                done_d  = 1'b1;
            end else begin
                state_d = ST_COLLECTING;
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            asm_q   <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    assign output_data          = out_q;
    assign deserialization_done = done_q;
    assign busy                 = (state_q == ST_COLLECTING);

endmodule : deserializer
`default_nettype wire

// File: tb/tb_deserializer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_deserializer
// Description : Self-checking bench for deserializer. Directed steps drive
//               chunks; expected frames are queued when a frame's last chunk
//               is driven and compared when the done pulse appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_deserializer;

    localparam int IW = 16;
    localparam int OW = 256;
    localparam int NC = OW / IW;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          input_valid;
    logic [IW-1:0] input_data;
    logic          flush;
    logic [OW-1:0] output_data;
    logic          deserialization_done;
    logic          busy;

    deserializer #(
        .INPUT_SIZE  (IW),
        .OUTPUT_SIZE (OW),
        .WORD_SIZE   (32)
    ) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .input_valid          (input_valid),
        .input_data           (input_data),
        .flush                (flush),
        .output_data          (output_data),
        .deserialization_done (deserialization_done),
        .busy                 (busy)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    int            done_cnt = 0;
    int            done_cyc[$];
    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] prev_out;
    logic          prev_done;
    logic [IW-1:0] chunks[NC];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every done pulse consumes one queued frame; between
    // pulses output_data must not move.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_out  = output_data;
            prev_done = 1'b0;
        end else begin
            if (deserialization_done) begin
                done_cnt++;
                done_cyc.push_back(cyc);
                if (exp_q.size() == 0) check("unexpected_done", 1, 0);
                else                   check("frame", output_data, exp_q.pop_front());
            end else begin
                check("out_stable", output_data, prev_out);
            end
            check("done_one_cycle", {255'b0, deserialization_done & prev_done}, 0);
            prev_out  = output_data;
            prev_done = deserialization_done;
        end
    end

    // Reference placement: chunk n -> word n/2, upper half when n is even.
    function automatic logic [OW-1:0] build_frame();
        logic [OW-1:0] f;
        int hi;
        f = '0;
        for (int n = 0; n < NC; n++) begin
            hi = (n / 2) * 32 + 31 - (n % 2) * 16;
            f[hi -: IW] = chunks[n];
        end
        return f;
    endfunction

    // Serializer model: frame -> chunk stream in the same order.
    task automatic serialize(input logic [OW-1:0] f);
        int hi;
        for (int n = 0; n < NC; n++) begin
            hi = (n / 2) * 32 + 31 - (n % 2) * 16;
            chunks[n] = f[hi -: IW];
        end
    endtask

    // Entered and left at posedge+1.
    task automatic drive(input logic v, input logic [IW-1:0] d, input logic f);
        input_valid = v;
        input_data  = d;
        flush       = f;
        @(posedge clk);
        #1;
        input_valid = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, '0, 1'b0);
    endtask

    // Sends chunks[] as one frame with optional 1..maxgap idle cycles between
    // chunks; checks busy along the way and the done pulse right after.
    task automatic send_frame(input int maxgap);
        for (int i = 0; i < NC; i++) begin
            if (i == NC - 1) exp_q.push_back(build_frame());
            drive(1'b1, chunks[i], 1'b0);
            if (i < NC - 1) begin
                check("busy_mid", {255'b0, busy}, 1);
                if (maxgap > 0) begin
                    idle($urandom_range(maxgap, 1));
                    check("busy_gap", {255'b0, busy}, 1);
                end
            end
        end
        check("done_after_last", {255'b0, deserialization_done}, 1);
        check("busy_after_last", {255'b0, busy}, 0);
    endtask

    initial begin
        int            d0;
        logic [OW-1:0] f;
        logic          dead_seen;

        reset_n     = 1'b0;
        input_valid = 1'b0;
        input_data  = '0;
        flush       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out",  output_data, 0);
        check("rst_done", {255'b0, deserialization_done}, 0);
        check("rst_busy", {255'b0, busy}, 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Contiguous frame 0x0001..0x0010
        for (int i = 0; i < NC; i++) chunks[i] = IW'(i + 1);
        d0 = done_cnt;
        send_frame(0);
        check("c_w0_hi", {240'b0, output_data[31:16]},   256'h0001);
        check("c_w0_lo", {240'b0, output_data[15:0]},    256'h0002);
        check("c_w7_hi", {240'b0, output_data[255:240]}, 256'h000F);
        check("c_w7_lo", {240'b0, output_data[239:224]}, 256'h0010);
        idle(1);
        check("c_done_count", 256'(done_cnt - d0), 1);
        check("c_done_low", {255'b0, deserialization_done}, 0);

        // Same chunks with 1..3 idle cycles between them
        d0 = done_cnt;
        send_frame(3);
        idle(2);
        check("g_done_count", 256'(done_cnt - d0), 1);

        // Back-to-back frames A and B, no bubble
        for (int i = 0; i < NC; i++) chunks[i] = 16'hA000 + IW'(i);
        d0 = done_cnt;
        send_frame(0);
        for (int i = 0; i < NC; i++) chunks[i] = 16'hB000 + IW'(i);
        send_frame(0);
        idle(1);
        check("b2b_done_count", 256'(done_cnt - d0), 2);
        if (done_cyc.size() >= 2)
            check("b2b_spacing", 256'(done_cyc[$] - done_cyc[$-1]), 16);
        else
            check("b2b_spacing_missing", 256'(done_cyc.size()), 2);

        // Flush mid-frame, flush colliding with a valid 0xDEAD chunk
        f  = output_data;
        d0 = done_cnt;
        for (int i = 0; i < 5; i++) drive(1'b1, 16'h5000 + IW'(i), 1'b0);
        drive(1'b1, 16'hDEAD, 1'b1);
        check("flush_busy", {255'b0, busy}, 0);
        idle(3);
        check("flush_no_done", 256'(done_cnt - d0), 0);
        check("flush_out_kept", output_data, f);
        for (int i = 0; i < NC; i++) chunks[i] = 16'hC000 + IW'(i);
        send_frame(0);
        dead_seen = 1'b0;
        for (int i = 0; i < NC; i++)
            if (output_data[i*IW +: IW] == 16'hDEAD) dead_seen = 1'b1;
        check("flush_no_dead", {255'b0, dead_seen}, 0);
        idle(1);

        // Asynchronous reset after 9 chunks
        for (int i = 0; i < 9; i++) drive(1'b1, 16'h9000 + IW'(i), 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_out",  output_data, 0);
        check("arst_done", {255'b0, deserialization_done}, 0);
        check("arst_busy", {255'b0, busy}, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < NC; i++) chunks[i] = 16'h7700 + IW'(i * 3);
        send_frame(0);
        idle(1);

        // Loopback through the serializer model with random frames
        for (int t = 0; t < 3; t++) begin
            for (int k = 0; k < OW / 32; k++) f[k*32 +: 32] = $urandom;
            serialize(f);
            d0 = done_cnt;
            send_frame(t);
            check("loop_frame", output_data, f);
            idle(1);
            check("loop_done_count", 256'(done_cnt - d0), 1);
        end

        idle(2);
        check("queue_drained", 256'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_deserializer
`default_nettype wire
